rr_arb_mux: RTL and testbench
=============================

// Module: rr_arb_mux
// PURPOSE
//  Parametrised N-input, packet-aware arbitrating mux for a NoC router output port.
//  Selects one input by round-robin and holds that grant for the whole packet (until last beat).
//  Forwards beats through one registered output stage with valid/ready handshakes on both sides.
//  Sits between the input buffers and the output link; replaces the plain combinational select.
// PARAMETERS
//  N_IN    4   number of input channels (>=2)
//  DATA_W  32  flit/beat data width in bits
//  IDX_W   derived = max(1,$clog2(N_IN)); width of index fields (localparam)
// PORTS
//  clk        in   1             clock, all state on rising edge
//  rst_n      in   1             asynchronous active-low reset
//  in_valid   in   N_IN          per-input beat valid
//  in_data    in   N_IN*DATA_W   input i data at [i*DATA_W +: DATA_W]
//  in_last    in   N_IN          per-input last-beat-of-packet flag
//  in_ready   out  N_IN          per-input ready; one-hot or zero
//  out_valid  out  1             registered output beat valid
//  out_data   out  DATA_W        registered output data
//  out_last   out  1             registered last flag
//  out_ready  in   1             downstream ready
//  grant_idx  out  IDX_W         index of locked input (valid while busy=1)
//  busy       out  1             1 while a packet is locked (state LOCKED)
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, rr_ptr=0, grant_idx=0, busy=0, out_valid=0,
//   out_data=0, out_last=0, in_ready=0. Any packet in flight is discarded.
//  FSM: IDLE -> LOCKED when any in_valid=1. grant = first i with in_valid[i], scanning
//   rr_ptr, rr_ptr+1, ... mod N_IN. Latch it into grant_idx. No beat is accepted in IDLE.
//  LOCKED -> IDLE on the edge that accepts a beat from grant_idx with in_last=1.
//   On that edge rr_ptr <= (grant_idx+1) mod N_IN (wrap N_IN-1 -> 0).
//  in_ready[i] = busy && (i==grant_idx) && (!out_valid || out_ready). All other bits are 0.
//  Accept = in_valid[g] && in_ready[g]. On accept: out_data/out_last <= input g, out_valid <= 1.
//  No accept while out_valid && out_ready: out_valid <= 0. Otherwise out regs hold.
//  While out_valid=1 && out_ready=0, out_data and out_last are stable.
//  Latency: request in cycle 0 (IDLE), grant/in_ready in cycle 1, first beat on out_valid in cycle 2.
//   Then 1 beat/cycle with no backpressure. One idle cycle per packet for arbitration.
//  The lock is kept through in_valid gaps mid-packet. Other inputs' requests are ignored until the last beat.
//  Inputs that drop in_valid before being granted lose no state; the mux has no request memory.
//  Single-beat packet (in_last on the first beat): LOCKED for exactly one accept, then IDLE.
//  Same-cycle last-beat accept and new requests: arbitration happens in the following IDLE cycle using the updated rr_ptr.
//  in_data/in_last of non-granted inputs never reach the output. No X propagation from idle inputs.
// TESTING
//  1 Reset mid-packet: assert rst_n=0 during in2 beat 2 of 4 -> out_valid=0, busy=0, in_ready=0.
//    Next grant after release is searched from rr_ptr=0.
//  2 in2 sends 2 beats 0xA1,0xA2 (last on 2nd), out_ready=1 -> grant_idx=2, in_ready=4'b0100 in cycle 1.
//    out_data=0xA1 cycle 2, 0xA2 with out_last=1 cycle 3, busy=0 after.
//  3 All 4 inputs send back-to-back single-beat packets -> grant order 0,1,2,3,0,1.
//    A beat every 2 cycles.
//  4 in0 sends a 4-beat packet while in1 requests throughout -> in1 in_ready=0 until in0 last is accepted.
//    Next grant=1 (rr_ptr=1).
//  5 out_ready=0 for 3 cycles with out_valid=1, data 0x55 -> out_data stays 0x55, in_ready all 0.
//    Resume: each input beat appears exactly once, in order.
//  6 in3 packet with in_valid low 2 cycles mid-packet while in0 requests -> grant stays 3.
//    out_valid drops after drain; in0 is granted only after in3 last.

Source files
------------

// File: rtl/rr_arb_mux.sv
// Packet-aware round-robin arbitrating mux with a single registered output stage.
// One input is locked from arbitration until its last beat is accepted; downstream
// backpressure stalls the locked input through in_ready.
module rr_arb_mux #(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned DATA_W = 32,
    localparam int unsigned IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_IN-1:0]          in_valid,
    input  logic [N_IN*DATA_W-1:0]   in_data,
    input  logic [N_IN-1:0]          in_last,
    output logic [N_IN-1:0]          in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic [IDX_W-1:0]         grant_idx,
    output logic                     busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    rr_ptr_nxt;
    logic                arb_hit;
    logic [IDX_W-1:0]    arb_idx;
    int unsigned         arb_cand;
    logic                sel_valid;
    logic                sel_last;
    logic [DATA_W-1:0]   sel_data;
    logic                out_free;
    logic                accept;

    assign busy     = (state == LOCKED);
    assign out_free = !out_valid || out_ready;
    assign accept   = busy && sel_valid && out_free;

    // Round-robin search: first requesting input starting at rr_ptr, wrapping modulo N_IN.
    always_comb begin
        arb_hit  = 1'b0;
        arb_idx  = '0;
        arb_cand = 0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            arb_cand = (32'(rr_ptr) + k) % N_IN;
            if (!arb_hit && in_valid[IDX_W'(arb_cand)]) begin
                arb_hit = 1'b1;
                arb_idx = IDX_W'(arb_cand);
            end
        end
    end

    // Select the locked input's beat; non-granted inputs never reach the output.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (IDX_W'(i) == grant_idx) begin
                sel_valid = in_valid[i];
                sel_last  = in_last[i];
                sel_data  = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Pointer moves past the input whose packet just finished.
    always_comb begin
        rr_ptr_nxt = (grant_idx == IDX_W'(N_IN - 1)) ? '0 : grant_idx + 1'b1;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: lock on any request, release on the accepted last beat.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_hit)             state_nxt = LOCKED;
            LOCKED:  if (accept && sel_last)  state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    // Output decode: only the locked input sees ready, and only when the output slot frees.
    always_comb begin
        in_ready = '0;
        if (busy && out_free) begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                if (IDX_W'(i) == grant_idx) begin
                    in_ready[i] = 1'b1;
                end
            end
        end
    end

    // Grant and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_idx <= '0;
            rr_ptr    <= '0;
        end else begin
            if (state == IDLE && arb_hit) begin
                grant_idx <= arb_idx;
            end
            if (accept && sel_last) begin
                rr_ptr <= rr_ptr_nxt;
            end
        end
    end

    // Registered output stage: load on accept, drain when consumed, hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_last  <= sel_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: directed latency/reset scenarios, then randomized traffic
// against a packet-level reference model feeding an output scoreboard.
module tb_rr_arb_mux;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      in_valid;
    logic [N*DW-1:0]   in_data;
    logic [N-1:0]      in_last;
    logic [N-1:0]      in_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_last;
    logic              out_ready;
    logic [IW-1:0]     grant_idx;
    logic              busy;

    rr_arb_mux #(.N_IN(N), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    int    errors = 0;
    int    checks = 0;
    beat_t exp_q[$];
    bit    sb_on = 1'b0;

    // Reference model state (packet level)
    bit    m_locked;
    int    m_g;
    int    m_rr;
    bit    m_full;
    int    rem[N];
    int    seq[N];
    int    vprob;
    int    rprob;
    int    max_len;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every beat consumed downstream must match the oldest expected beat.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (sb_on && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got %0h with nothing expected at %0t", out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_data", 64'(out_data), 64'(e.d));
                    chk("sb_last", 64'(out_last), 64'(e.l));
                end
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            in_valid[i] = ($urandom_range(99) < vprob);
            if (in_valid[i] || $urandom_range(1) == 0) begin
                in_data[i*DW +: DW] = {8'(i), 24'(seq[i])};
                in_last[i]          = (rem[i] == 1);
            end else begin
                in_data[i*DW +: DW] = $urandom;
                in_last[i]          = 1'($urandom);
            end
        end
        out_ready = ($urandom_range(99) < rprob);
    endtask

    // Compare DUT against the model mid-cycle, then advance the model on the edge.
    task automatic step_model();
        logic [N-1:0] exp_rdy;
        bit           acc;
        bit           last_acc;
        int           c;
        @(negedge clk);
        exp_rdy = '0;
        if (m_locked && (!m_full || out_ready)) exp_rdy[m_g] = 1'b1;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("busy", 64'(busy), 64'(m_locked));
        chk("out_valid", 64'(out_valid), 64'(m_full));
        if (m_locked) chk("grant_idx", 64'(grant_idx), 64'(m_g));
        acc      = m_locked && in_valid[m_g] && exp_rdy[m_g];
        last_acc = acc && in_last[m_g];
        @(posedge clk);
        if (acc) begin
            exp_q.push_back({in_data[m_g*DW +: DW], in_last[m_g]});
            seq[m_g]++;
            rem[m_g]--;
            if (rem[m_g] == 0) rem[m_g] = $urandom_range(max_len, 1);
            m_full = 1'b1;
        end else if (out_ready) begin
            m_full = 1'b0;
        end
        if (!m_locked) begin
            for (int k = 0; k < N; k++) begin
                c = (m_rr + k) % N;
                if (!m_locked && in_valid[c]) begin
                    m_locked = 1'b1;
                    m_g      = c;
                end
            end
        end else if (last_acc) begin
            m_locked = 1'b0;
            m_rr     = (m_g + 1) % N;
        end
        #1;
    endtask

    initial begin
        in_valid  = '0;
        in_data   = '0;
        in_last   = '0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_in_ready", 64'(in_ready), 0);
        chk("rst_grant", 64'(grant_idx), 0);
        chk("rst_out_data", 64'(out_data), 0);
        chk("rst_out_last", 64'(out_last), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Two-beat packet from input 2
        in_valid = 4'b0100;
        in_data[2*DW +: DW] = 32'hA1;
        @(negedge clk);
        chk("t2_c0_in_ready", 64'(in_ready), 0);
        chk("t2_c0_busy", 64'(busy), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t2_c1_busy", 64'(busy), 1);
        chk("t2_c1_grant", 64'(grant_idx), 2);
        chk("t2_c1_in_ready", 64'(in_ready), 64'(4'b0100));
        chk("t2_c1_out_valid", 64'(out_valid), 0);
        @(posedge clk); #1;
        in_data[2*DW +: DW] = 32'hA2;
        in_last = 4'b0100;
        @(negedge clk);
        chk("t2_c2_out_valid", 64'(out_valid), 1);
        chk("t2_c2_out_data", 64'(out_data), 64'h A1);
        chk("t2_c2_out_last", 64'(out_last), 0);
        @(posedge clk); #1;
        in_valid = '0;
        in_last  = '0;
        @(negedge clk);
        chk("t2_c3_out_data", 64'(out_data), 64'hA2);
        chk("t2_c3_out_last", 64'(out_last), 1);
        chk("t2_c3_busy", 64'(busy), 0);
        @(posedge clk); #1;

        // Reset in the middle of a 4-beat packet from input 2
        in_valid = 4'b0100;
        in_data[2*DW +: DW] = 32'hB1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_data[2*DW +: DW] = 32'hB2;
        @(posedge clk); #1;
        in_data[2*DW +: DW] = 32'hB3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 0);
        chk("rst_mid_busy", 64'(busy), 0);
        chk("rst_mid_in_ready", 64'(in_ready), 0);
        in_valid = '0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        // Pointer must restart at 0: inputs 1 and 3 compete, input 1 wins
        in_valid = 4'b1010;
        in_last  = 4'b1010;
        in_data[1*DW +: DW] = 32'hC1;
        in_data[3*DW +: DW] = 32'hC3;
        @(negedge clk);
        chk("rr_reset_idle", 64'(busy), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rr_reset_grant", 64'(grant_idx), 1);
        chk("rr_reset_in_ready", 64'(in_ready), 64'(4'b0010));
        @(posedge clk); #1;
        in_valid = '0;
        in_last  = '0;
        @(negedge clk);
        chk("rr_reset_data", 64'(out_data), 64'hC1);
        chk("rr_reset_busy", 64'(busy), 0);

        // Randomized traffic against the model
        rst_n = 1'b0;
        m_locked = 1'b0;
        m_g      = 0;
        m_rr     = 0;
        m_full   = 1'b0;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            rem[i] = 1;
            seq[i] = 0;
        end
        @(negedge clk) rst_n = 1'b1;
        sb_on = 1'b1;
        @(posedge clk); #1;

        for (int ep = 0; ep < 5; ep++) begin
            case (ep)
                0:       begin vprob = 100; rprob = 100; max_len = 1; end
                1:       begin vprob = 70;  rprob = 70;  max_len = 4; end
                2:       begin vprob = 50;  rprob = 30;  max_len = 4; end
                3:       begin vprob = 90;  rprob = 100; max_len = 6; end
                default: begin vprob = 30;  rprob = 85;  max_len = 3; end
            endcase
            repeat (600) begin
                drive();
                step_model();
            end
        end

        // Drain: hold inputs idle until the output stage empties
        vprob = 0;
        rprob = 100;
        repeat (8) begin
            drive();
            step_model();
        end
        chk("sb_empty", 64'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
